// File: rtl/poly_voice_synth.sv
// poly_voice_synth: polyphonic square-wave synthesiser.
// Maps a bank of NUM_KEYS keys onto NUM_VOICES voices. Each voice has its own
// half-period divider. The voices are summed into a registered mix count and a
// first-order sigma-delta PDM bit.
// Optional feature macro: VOICE_STEAL_EN. When it is defined, a new key press
// with no free voice evicts the voice at a round-robin pointer. Evicted keys
// are then masked as dropped until they are released.
module poly_voice_synth #(
  parameter int NUM_KEYS   = 12,
  parameter int NUM_VOICES = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ena,
  input  logic [NUM_KEYS-1:0]               keys,
  input  logic [2:0]                        octave,
  output logic [NUM_VOICES-1:0]             voice_active,
  output logic [NUM_VOICES-1:0]             voice_tone,
  output logic [$clog2(NUM_VOICES+1)-1:0]   mix,
  output logic                              pdm
);
  localparam int KW = $clog2(NUM_KEYS);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int MW = $clog2(NUM_VOICES + 1);
  localparam int AW = VW + 1;

  logic [NUM_KEYS-1:0]  keys_q;
  logic [NUM_KEYS-1:0]  eff_keys;
  logic [NUM_KEYS-1:0]  held;
  logic [NUM_KEYS-1:0]  blocked;
  logic [KW-1:0]        key_idx [NUM_VOICES];
  logic [DIV_WIDTH-1:0] div_val [NUM_VOICES];
  logic [DIV_WIDTH-1:0] cnt     [NUM_VOICES];
  logic [NUM_VOICES-1:0] active;
  logic [NUM_VOICES-1:0] tone;
  logic [AW-1:0]        acc;
  logic [AW-1:0]        pdm_sum;
  logic [MW-1:0]        pop;
  logic                 cand_found;
  logic                 free_found;
  logic                 alloc_en;
  logic [KW-1:0]        cand_key;
  logic [VW-1:0]        free_v;
  logic [VW-1:0]        alloc_v;
  logic [DIV_WIDTH-1:0] alloc_div;
  int                   key_i;
  int                   oct_i;
`ifdef VOICE_STEAL_EN
  logic [NUM_KEYS-1:0]  dropped;
  logic [NUM_KEYS-1:0]  dropped_n;
  logic [VW-1:0]        sp;
`endif

  // Half-period of each note at octave 0 (about C4) for a 10 MHz clock.
  function automatic logic [15:0] base_half_period(input int note);
    case (note)
      0:       return 16'd19111;
      1:       return 16'd18039;
      2:       return 16'd17026;
      3:       return 16'd16071;
      4:       return 16'd15169;
      5:       return 16'd14317;
      6:       return 16'd13514;
      7:       return 16'd12755;
      8:       return 16'd12039;
      9:       return 16'd11364;
      10:      return 16'd10726;
      default: return 16'd10124;
    endcase
  endfunction

  // Pick the candidate key and the target voice, and work out the divisor for the new note.
  always_comb begin
    eff_keys = ena ? keys_q : '0;
    held = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (active[v]) held[key_idx[v]] = 1'b1;
    end
    blocked = held;
`ifdef VOICE_STEAL_EN
    blocked = held | dropped;
`endif
    // The loop runs downwards so that the lowest index wins.
    cand_found = 1'b0;
    cand_key   = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (eff_keys[k] && !blocked[k]) begin
        cand_found = 1'b1;
        cand_key   = KW'(k);
      end
    end
    // A voice freed on this edge still counts as busy here.
    free_found = 1'b0;
    free_v     = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active[v]) begin
        free_found = 1'b1;
        free_v     = VW'(v);
      end
    end
    alloc_en = cand_found && free_found;
    alloc_v  = free_v;
`ifdef VOICE_STEAL_EN
    dropped_n = dropped & eff_keys;
    if (cand_found && !free_found) begin
      alloc_en = 1'b1;
      alloc_v  = sp;
      dropped_n[key_idx[sp]] = eff_keys[key_idx[sp]];
    end
`endif
    key_i = int'(cand_key);
    oct_i = int'(octave) + key_i / 12;
    if (oct_i > 7) oct_i = 7;
    alloc_div = DIV_WIDTH'(base_half_period(key_i % 12) >> oct_i);
    pop = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (active[v] && tone[v]) pop = pop + MW'(1);
    end
    pdm_sum = acc + AW'(mix);
  end

  // Register the key levels, the mix, the PDM state and every voice.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q <= '0;
      active <= '0;
      tone   <= '0;
      mix    <= '0;
      acc    <= '0;
      pdm    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_idx[v] <= '0;
        div_val[v] <= '0;
        cnt[v]     <= '0;
      end
    end else begin
      keys_q <= keys;
      mix    <= pop;
      if (!ena) begin
        acc <= '0;
        pdm <= 1'b0;
      end else if (pdm_sum >= AW'(NUM_VOICES)) begin
        acc <= pdm_sum - AW'(NUM_VOICES);
        pdm <= 1'b1;
      end else begin
        acc <= pdm_sum;
        pdm <= 1'b0;
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (alloc_en && alloc_v == VW'(v)) begin
          active[v]  <= 1'b1;
          key_idx[v] <= cand_key;
          div_val[v] <= alloc_div;
          cnt[v]     <= '0;
          tone[v]    <= 1'b0;
        end else if (active[v] && !eff_keys[key_idx[v]]) begin
          active[v] <= 1'b0;
          tone[v]   <= 1'b0;
          cnt[v]    <= '0;
        end else if (active[v]) begin
          if (cnt[v] == div_val[v] - DIV_WIDTH'(1)) begin
            cnt[v]  <= '0;
            tone[v] <= ~tone[v];
          end else begin
            cnt[v] <= cnt[v] + DIV_WIDTH'(1);
          end
        end
      end
    end
  end

`ifdef VOICE_STEAL_EN
  // Track the dropped-key mask and advance the steal pointer on each eviction.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropped <= '0;
      sp      <= '0;
    end else begin
      dropped <= dropped_n;
      if (cand_found && !free_found) begin
        sp <= (sp == VW'(NUM_VOICES - 1)) ? '0 : sp + VW'(1);
      end
    end
  end
`endif

  assign voice_active = active;
  assign voice_tone   = tone;

endmodule
